id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between the Decode (ID) and Execute (EX) stages of the ARM pipeline, combined with load-use and RAW hazard interlock. It captures the decoded instruction bundle each cycle, presents the EX-stage register addresses and write-back controls to the forwarding logic, and inserts bubbles when the instruction in ID cannot proceed. It stalls PC and IF/ID via `hazard`, honours memory-stall `freeze` and branch `flush`, and optionally counts inserted bubbles.

## Interface
- `DATA_W`, 32, datapath width
- `REG_ADDR_W`, 4, register-file address width
- `CNT_W`, 16, bubble counter width
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm, id_two_src`  in  1 each  decoded controls
- `id_exe_cmd`  in  4  ALU command
- `id_pc, id_val_rn, id_val_rm`  in  DATA_W  PC and operand values
- `id_shift_operand`  in  12;  `id_signed_imm_24`  in  24;  `id_status`  in  4 (NZCV)
- `id_dest, id_src1, id_src2`  in  REG_ADDR_W  register addresses
- `mem_dest`  in  REG_ADDR_W;  `mem_wb_en`  in  1  MEM-stage writer
- `freeze`  in  1  memory stall; hold all state
- `flush`  in  1  branch taken; load bubble
- `forward_en`  in  1  forwarding active
- `ex_*`  out  same widths as `id_*` counterparts  registered bundle (including `ex_src1`, `ex_src2`, `ex_dest`, `ex_wb_en`, `ex_mem_r_en`)
- `hazard`  out  1  stall PC and IF/ID this cycle
- `bubble_cnt`  out  CNT_W  hazard bubbles inserted (macro-dependent)

## Operation
- A bubble is all `ex_*` = 0: `valid`, `wb_en`, `mem_r_en`, `mem_w_en`, `b` and `s` are all 0.
- src1 match: `id_valid && id_src1 == X`. src2 match: `id_valid && id_two_src && id_src2 == X`.
- `forward_en=1`: `hazard = ex_valid && ex_mem_r_en && ex_wb_en && (src1 or src2 matches ex_dest)`. This is load-use only.
- `forward_en=0`: `hazard` = (`ex_valid && ex_wb_en` and src1/src2 matches `ex_dest`) OR (`mem_wb_en` and src1/src2 matches `mem_dest`).
- `hazard` is combinational from current `ex_*` plus ID/MEM inputs. It is independent of `freeze` and `flush`.
- Register update priority per edge:
  - `freeze`: hold all state.
  - else `flush`: load bubble.
  - else `hazard`: load bubble.
  - else: load `id_*`.
- `id_valid=0` loads as-is; the bubble controls come from the decoder.
- `flush` and `hazard` in the same cycle: bubble. The counter does not increment.

## Timing
- Latency: 1 cycle, ID inputs to `ex_*`.
- `hazard` is valid in the same cycle as the inputs. It clears the cycle after the bubble is loaded, because `ex_mem_r_en` is then 0.
- A load-use stall lasts exactly 1 bubble with forwarding on. With forwarding off it lasts up to 2 bubbles: EX match, then MEM match.
- Reset (async assert, any cycle including mid-stall): all `ex_*` = 0, `bubble_cnt` = 0, so `hazard` evaluates to 0. Release takes effect at the next edge.
- `freeze` held N cycles: `ex_*` unchanged for N cycles, and `hazard` is re-evaluated each cycle against the held state.

## Configuration
- `ID_EX_BUBBLE_CNT_EN` defined:
  - `bubble_cnt` increments by 1 on each edge where a hazard bubble is loaded (`!freeze && !flush && hazard`).
  - Saturates at all-ones; no wrap.
- Undefined: `bubble_cnt` is tied to 0 and no counter flops exist.

## Structure
- Shared package `arm_pipe_pkg` contains:
  - `DATA_W`/`REG_ADDR_W` constants and `exe_cmd` encodings.
  - `id_ex_bundle_t` packed struct of all ID/EX fields.
  - `BUBBLE` constant of that type.
- One sub-module, `hazard_detect`: pure combinational hazard equation above, reused for both modes.

## Test plan
- Reset mid-stream: `rst_n`=0 with `ex_wb_en`=1, `ex_dest`=3 → all `ex_*`=0 and `hazard`=0 immediately; `bubble_cnt`=0.
- Load-use, `forward_en`=1: EX holds LDR R2 (`mem_r_en`=1, `wb_en`=1). ID ADD with `src1`=2 → `hazard`=1, next cycle `ex_valid`=0 and `hazard`=0, following cycle ADD is in EX; `bubble_cnt`=1.
- `forward_en`=0: EX ADD R5 writes; ID `src2`=5, `two_src`=1 → two bubbles (EX match, then MEM match); ADD enters EX on the 3rd edge; `bubble_cnt`=2.
- `two_src`=0 with `id_src2`==`ex_dest`=7, load in EX → `hazard`=0, no bubble.
- `flush` and `hazard` both 1 → bubble loaded, `bubble_cnt` unchanged. `freeze`=1 for 3 cycles → `ex_pc` stays 0x0000_0010 throughout.
- `ID_EX_BUBBLE_CNT_EN`, `CNT_W`=4: force 20 hazard bubbles → `bubble_cnt` = 15 (saturates).

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline types: datapath widths, ALU command encodings and the
// ID/EX bundle carried from decode into execute.
package arm_pipe_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 4;

    typedef logic [3:0] exe_cmd_t;

    localparam exe_cmd_t EXE_NOP = 4'b0000;
    localparam exe_cmd_t EXE_MOV = 4'b0001;
    localparam exe_cmd_t EXE_ADD = 4'b0010;
    localparam exe_cmd_t EXE_ADC = 4'b0011;
    localparam exe_cmd_t EXE_SUB = 4'b0100;
    localparam exe_cmd_t EXE_SBC = 4'b0101;
    localparam exe_cmd_t EXE_AND = 4'b0110;
    localparam exe_cmd_t EXE_ORR = 4'b0111;
    localparam exe_cmd_t EXE_EOR = 4'b1000;
    localparam exe_cmd_t EXE_MVN = 4'b1001;

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic                  b;
        logic                  s;
        logic                  imm;
        logic                  two_src;
        exe_cmd_t              exe_cmd;
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     val_rn;
        logic [DATA_W-1:0]     val_rm;
        logic [11:0]           shift_operand;
        logic [23:0]           signed_imm_24;
        logic [3:0]            status;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
    } id_ex_bundle_t;

    localparam id_ex_bundle_t BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW / load-use interlock for the instruction sitting in ID.
// With forwarding on only a load in EX stalls; with it off any EX or MEM writer does.
module hazard_detect
    import arm_pipe_pkg::*;
(
    input  logic                  id_valid,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  ex_valid,
    input  logic                  ex_wb_en,
    input  logic                  ex_mem_r_en,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  forward_en,
    output logic                  hazard
);

    logic match_ex;
    logic match_mem;

    assign match_ex  = (id_valid && id_src1 == ex_dest)
                     || (id_valid && id_two_src && id_src2 == ex_dest);
    assign match_mem = (id_valid && id_src1 == mem_dest)
                     || (id_valid && id_two_src && id_src2 == mem_dest);

    always_comb begin
        hazard = 1'b0;
        if (forward_en) begin
            hazard = ex_valid && ex_mem_r_en && ex_wb_en && match_ex;
        end else begin
            hazard = (ex_valid && ex_wb_en && match_ex) || (mem_wb_en && match_mem);
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard interlock; freeze holds, flush/hazard load a bubble.
// Optional saturating bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic                  id_b,
    input  logic                  id_s,
    input  logic                  id_imm,
    input  logic                  id_two_src,
    input  logic [3:0]            id_exe_cmd,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_val_rn,
    input  logic [DATA_W-1:0]     id_val_rm,
    input  logic [11:0]           id_shift_operand,
    input  logic [23:0]           id_signed_imm_24,
    input  logic [3:0]            id_status,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  forward_en,
    output logic                  ex_valid,
    output logic                  ex_wb_en,
    output logic                  ex_mem_r_en,
    output logic                  ex_mem_w_en,
    output logic                  ex_b,
    output logic                  ex_s,
    output logic                  ex_imm,
    output logic                  ex_two_src,
    output logic [3:0]            ex_exe_cmd,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_val_rn,
    output logic [DATA_W-1:0]     ex_val_rm,
    output logic [11:0]           ex_shift_operand,
    output logic [23:0]           ex_signed_imm_24,
    output logic [3:0]            ex_status,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [REG_ADDR_W-1:0] ex_src1,
    output logic [REG_ADDR_W-1:0] ex_src2,
    output logic                  hazard,
    output logic [CNT_W-1:0]      bubble_cnt
);

    import arm_pipe_pkg::id_ex_bundle_t;
    import arm_pipe_pkg::BUBBLE;

    id_ex_bundle_t id_bus;
    id_ex_bundle_t ex_q;

    assign id_bus = '{valid:         id_valid,
                      wb_en:         id_wb_en,
                      mem_r_en:      id_mem_r_en,
                      mem_w_en:      id_mem_w_en,
                      b:             id_b,
                      s:             id_s,
                      imm:           id_imm,
                      two_src:       id_two_src,
                      exe_cmd:       id_exe_cmd,
                      pc:            id_pc,
                      val_rn:        id_val_rn,
                      val_rm:        id_val_rm,
                      shift_operand: id_shift_operand,
                      signed_imm_24: id_signed_imm_24,
                      status:        id_status,
                      dest:          id_dest,
                      src1:          id_src1,
                      src2:          id_src2};

    hazard_detect u_hazard_detect (
        .id_valid    (id_valid),
        .id_two_src  (id_two_src),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .ex_valid    (ex_q.valid),
        .ex_wb_en    (ex_q.wb_en),
        .ex_mem_r_en (ex_q.mem_r_en),
        .ex_dest     (ex_q.dest),
        .mem_wb_en   (mem_wb_en),
        .mem_dest    (mem_dest),
        .forward_en  (forward_en),
        .hazard      (hazard)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= BUBBLE;
        end else if (!freeze) begin
            if (flush || hazard) begin
                ex_q <= BUBBLE;
            end else begin
                ex_q <= id_bus;
            end
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // only interlock bubbles count; a flush that coincides with a hazard does not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!freeze && !flush && hazard && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bubble_cnt = cnt_q;
`else
    assign bubble_cnt = '0;
`endif

    assign ex_valid         = ex_q.valid;
    assign ex_wb_en         = ex_q.wb_en;
    assign ex_mem_r_en      = ex_q.mem_r_en;
    assign ex_mem_w_en      = ex_q.mem_w_en;
    assign ex_b             = ex_q.b;
    assign ex_s             = ex_q.s;
    assign ex_imm           = ex_q.imm;
    assign ex_two_src       = ex_q.two_src;
    assign ex_exe_cmd       = ex_q.exe_cmd;
    assign ex_pc            = ex_q.pc;
    assign ex_val_rn        = ex_q.val_rn;
    assign ex_val_rm        = ex_q.val_rm;
    assign ex_shift_operand = ex_q.shift_operand;
    assign ex_signed_imm_24 = ex_q.signed_imm_24;
    assign ex_status        = ex_q.status;
    assign ex_dest          = ex_q.dest;
    assign ex_src1          = ex_q.src1;
    assign ex_src2          = ex_q.src2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then randomized traffic
// against a list-based model of the interlock rules.
module tb_id_ex_stage;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic        valid;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic        imm;
        logic        two_src;
        logic [3:0]  exe_cmd;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  status;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } bndl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bndl_t      drv;
    logic [3:0] mem_dest;
    logic       mem_wb_en, freeze, flush, forward_en;

    logic        ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm, ex_two_src;
    logic [3:0]  ex_exe_cmd, ex_status, ex_dest, ex_src1, ex_src2;
    logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
    logic [11:0] ex_shift_operand;
    logic [23:0] ex_signed_imm_24;
    logic        hazard;
    logic [CNT_W-1:0] bubble_cnt;
    bndl_t       dut_ex;

    assign dut_ex = {ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm,
                     ex_two_src, ex_exe_cmd, ex_pc, ex_val_rn, ex_val_rm, ex_shift_operand,
                     ex_signed_imm_24, ex_status, ex_dest, ex_src1, ex_src2};

    id_ex_stage #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(drv.valid), .id_wb_en(drv.wb_en), .id_mem_r_en(drv.mem_r_en),
        .id_mem_w_en(drv.mem_w_en), .id_b(drv.b), .id_s(drv.s), .id_imm(drv.imm),
        .id_two_src(drv.two_src), .id_exe_cmd(drv.exe_cmd), .id_pc(drv.pc),
        .id_val_rn(drv.val_rn), .id_val_rm(drv.val_rm), .id_shift_operand(drv.shift_operand),
        .id_signed_imm_24(drv.signed_imm_24), .id_status(drv.status), .id_dest(drv.dest),
        .id_src1(drv.src1), .id_src2(drv.src2),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .freeze(freeze), .flush(flush),
        .forward_en(forward_en),
        .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b), .ex_s(ex_s), .ex_imm(ex_imm),
        .ex_two_src(ex_two_src), .ex_exe_cmd(ex_exe_cmd), .ex_pc(ex_pc),
        .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_shift_operand(ex_shift_operand),
        .ex_signed_imm_24(ex_signed_imm_24), .ex_status(ex_status), .ex_dest(ex_dest),
        .ex_src1(ex_src1), .ex_src2(ex_src2),
        .hazard(hazard), .bubble_cnt(bubble_cnt)
    );

    // reference state: what EX holds, what the downstream MEM stage holds, bubbles seen
    bndl_t      m_ex;
    logic       m_mem_wb;
    logic [3:0] m_mem_dest;
    int         m_cnt;
    bit         auto_mem;
    int         n_vec  = 0;
    int         n_fail = 0;

    function automatic logic model_hazard();
        logic [3:0] srcs[$];
        logic [3:0] writers[$];
        if (drv.valid) begin
            srcs.push_back(drv.src1);
            if (drv.two_src) srcs.push_back(drv.src2);
        end
        if (forward_en) begin
            if (m_ex.valid && m_ex.wb_en && m_ex.mem_r_en) writers.push_back(m_ex.dest);
        end else begin
            if (m_ex.valid && m_ex.wb_en) writers.push_back(m_ex.dest);
            if (mem_wb_en) writers.push_back(mem_dest);
        end
        foreach (srcs[i])
            foreach (writers[j])
                if (srcs[i] == writers[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef ID_EX_BUBBLE_CNT_EN
        return CNT_W'(m_cnt);
`else
        return '0;
`endif
    endfunction

    function automatic bndl_t mk(logic v, logic wb, logic mr, logic two, logic [3:0] d,
                                 logic [3:0] s1, logic [3:0] s2, logic [31:0] pc);
        bndl_t t;
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        t = r[159:0];
        t.valid = v; t.wb_en = wb; t.mem_r_en = mr; t.two_src = two;
        t.mem_w_en = 1'b0; t.b = 1'b0; t.s = 1'b0;
        t.exe_cmd = 4'b0010;
        t.dest = d; t.src1 = s1; t.src2 = s2; t.pc = pc;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ex = '0; m_mem_wb = 1'b0; m_mem_dest = '0; m_cnt = 0;
    endtask

    // called just after a falling edge with ID inputs already driven
    task automatic step(input string tag);
        logic hz;
        if (auto_mem) begin
            mem_dest  = m_mem_dest;
            mem_wb_en = m_mem_wb;
        end
        #1;
        hz = model_hazard();
        chk({tag, ".hazard"}, 256'(hazard), 256'(hz));
        @(posedge clk);
        if (!freeze) begin
            if (!flush && hz && m_cnt < CNT_MAX) m_cnt++;
            m_mem_wb   = m_ex.valid && m_ex.wb_en;
            m_mem_dest = m_ex.dest;
            if (flush || hz) m_ex = '0;
            else             m_ex = drv;
        end
        #1;
        chk({tag, ".ex"}, 256'(dut_ex), 256'(m_ex));
        chk({tag, ".cnt"}, 256'(bubble_cnt), 256'(exp_cnt()));
        @(negedge clk);
    endtask

    initial begin
        drv = '0; mem_dest = '0; mem_wb_en = 1'b0;
        freeze = 1'b0; flush = 1'b0; forward_en = 1'b1; auto_mem = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.ex", 256'(dut_ex), 256'(m_ex));
        chk("reset.hazard", 256'(hazard), 256'(1'b0));
        chk("reset.cnt", 256'(bubble_cnt), 256'(exp_cnt()));
        rst_n = 1'b1;

        // asynchronous reset while EX holds a writer of R3 that ID depends on
        forward_en = 1'b0;
        drv = mk(1, 1, 0, 0, 4'd3, 4'd1, 4'd0, 32'h4);
        step("pre_rst");
        drv = mk(1, 1, 0, 0, 4'd4, 4'd3, 4'd0, 32'h8);
        #2 rst_n = 1'b0;
        mem_wb_en = 1'b0;
        model_reset();
        #1;
        chk("midrst.ex", 256'(dut_ex), 256'(m_ex));
        chk("midrst.hazard", 256'(hazard), 256'(1'b0));
        chk("midrst.cnt", 256'(bubble_cnt), 256'(exp_cnt()));
        @(negedge clk);
        rst_n = 1'b1;

        // load-use with forwarding: exactly one bubble
        forward_en = 1'b1;
        drv = mk(1, 1, 1, 0, 4'd2, 4'd9, 4'd0, 32'h8);
        step("lu_ldr");
        drv = mk(1, 1, 0, 0, 4'd6, 4'd2, 4'd0, 32'hC);
        step("lu_stall");
        chk("lu_bubble.valid", 256'(ex_valid), 256'(1'b0));
        step("lu_resume");
        chk("lu_resume.pc", 256'(ex_pc), 256'(32'hC));

        // no forwarding: EX match then MEM match, ADD enters on third edge
        forward_en = 1'b0;
        drv = mk(1, 1, 0, 0, 4'd5, 4'd1, 4'd0, 32'h10);
        step("nf_add_r5");
        drv = mk(1, 1, 0, 1, 4'd10, 4'd8, 4'd5, 32'h14);
        step("nf_ex_match");
        step("nf_mem_match");
        step("nf_enter");
        chk("nf_enter.dest", 256'(ex_dest), 256'(4'd10));

        // src2 ignored when the instruction has a single source
        forward_en = 1'b1;
        drv = mk(1, 1, 1, 0, 4'd7, 4'd0, 4'd0, 32'h18);
        step("one_src_ldr");
        drv = mk(1, 1, 0, 0, 4'd11, 4'd1, 4'd7, 32'h1C);
        step("one_src");

        // flush coinciding with a hazard: bubble, counter unchanged
        drv = mk(1, 1, 1, 0, 4'd2, 4'd9, 4'd0, 32'h20);
        step("fl_ldr");
        drv = mk(1, 1, 0, 0, 4'd6, 4'd2, 4'd0, 32'h24);
        flush = 1'b1;
        step("fl_hz");
        flush = 1'b0;

        // freeze for three cycles holds the captured PC
        drv = mk(1, 0, 0, 0, 4'd1, 4'd12, 4'd0, 32'h10);
        step("fz_load");
        freeze = 1'b1;
        drv = mk(1, 1, 0, 0, 4'd1, 4'd13, 4'd0, 32'h30);
        for (int k = 0; k < 3; k++) begin
            step("fz_hold");
            chk("fz_hold.pc", 256'(ex_pc), 256'(32'h10));
        end
        freeze = 1'b0;

        // twenty interlock bubbles drive the counter into saturation
        for (int k = 0; k < 20; k++) begin
            drv = mk(1, 1, 1, 0, 4'd2, 4'd9, 4'd0, 32'(k * 8 + 32'h100));
            step("sat_ldr");
            drv = mk(1, 1, 0, 0, 4'd6, 4'd2, 4'd0, 32'(k * 8 + 32'h104));
            step("sat_use");
        end

        // randomized traffic with small register space to force collisions
        auto_mem = 1'b0;
        for (int k = 0; k < 300; k++) begin
            drv = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     4'($urandom_range(0, 3)), $urandom);
            drv.b = 1'($urandom); drv.s = 1'($urandom); drv.mem_w_en = 1'($urandom);
            drv.exe_cmd = 4'($urandom);
            mem_dest   = 4'($urandom_range(0, 3));
            mem_wb_en  = 1'($urandom);
            forward_en = 1'($urandom);
            freeze     = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
